// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file arbiter.
// The struct field widths follow the DEF_* constants, so the top-level parameters track them.
package regfile_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                    vld;
        logic [DEF_ID_WIDTH-1:0] id;
    } rd_pipe_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// It scans upward from i_ptr and wraps. When i_lock_en is set, only i_lock_id may win.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    input  logic                i_lock_en,
    input  logic [ID_WIDTH-1:0] i_lock_id,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id,
    output logic                o_grant_vld
);

    logic [NUM_REQ-1:0] w_req_m;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign w_req_m[gi] = i_req[gi] & (~i_lock_en | (i_lock_id == ID_WIDTH'(gi)));
            assign o_grant[gi] = o_grant_vld & (o_grant_id == ID_WIDTH'(gi));
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest valid requester wins last.
    always_comb begin
        int j;
        j           = 0;
        o_grant_id  = '0;
        o_grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (w_req_m[j]) begin
                o_grant_id  = ID_WIDTH'(j);
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that lets NUM_REQ clients share one single-port register file.
// Defining REGFILE_ARB_LOCK_EN enables grant locking through req_lock.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rf_wr_en,
    output logic                          rf_rd_en,
    output logic [ADDR_WIDTH-1:0]         rf_address,
    output logic [DATA_WIDTH-1:0]         rf_wr_data,
    input  logic [DATA_WIDTH-1:0]         rf_rd_data
);

    logic                  r_init_done;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    rd_pipe_t              r_s1;
    rd_pipe_t              r_s2;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_win_id;
    logic                  w_grant_vld;
    logic                  w_hs;
    logic                  w_lock_act;
    logic [ID_WIDTH-1:0]   w_lock_id;
    logic [ID_WIDTH-1:0]   w_ptr_next;
    cmd_t                  w_cmd;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .i_lock_en   (w_lock_act),
        .i_lock_id   (w_lock_id),
        .o_grant     (w_grant),
        .o_grant_id  (w_win_id),
        .o_grant_vld (w_grant_vld)
    );

    // Grants stay off until the register file's own synchronous reset has landed.
    assign req_ready = r_init_done ? w_grant : '0;
    assign w_hs      = r_init_done & w_grant_vld;

    assign w_cmd.we    = req_we[w_win_id];
    assign w_cmd.addr  = req_addr[w_win_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_cmd.wdata = req_wdata[w_win_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next  = (w_win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;

`ifdef REGFILE_ARB_LOCK_EN
    logic                r_lock_vld;
    logic [ID_WIDTH-1:0] r_lock_id;

    // A lock is honoured only while its owner keeps valid asserted.
    assign w_lock_act = r_lock_vld & req_valid[r_lock_id];
    assign w_lock_id  = r_lock_id;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
        end else if (w_hs) begin
            r_lock_vld <= req_lock[w_win_id];
            r_lock_id  <= w_win_id;
        end else if (r_lock_vld && !req_valid[r_lock_id]) begin
            r_lock_vld <= 1'b0;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
    assign w_lock_act    = 1'b0;
    assign w_lock_id     = '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_init_done <= 1'b0;
            r_ptr       <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
        end else begin
            r_init_done <= 1'b1;
            r_wr_en     <= w_hs & w_cmd.we;
            r_rd_en     <= w_hs & ~w_cmd.we;
            if (w_hs) begin
                r_addr  <= w_cmd.addr;
                r_wdata <= w_cmd.wdata;
            end
            if (w_hs && !w_lock_act) begin
                r_ptr <= w_ptr_next;
            end
            // Read data appears one cycle after rf_rd_en, so the strobe trails by two stages.
            r_s1.vld <= w_hs & ~w_cmd.we;
            r_s1.id  <= w_win_id;
            r_s2     <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = r_s2.vld & (r_s2.id == ID_WIDTH'(gi));
        end
    endgenerate

    assign rsp_rdata  = rf_rd_data;
    assign rf_wr_en   = r_wr_en;
    assign rf_rd_en   = r_rd_en;
    assign rf_address = r_addr;
    assign rf_wr_data = r_wdata;

endmodule
